// File: rtl/pts_unloader_if.sv
// rtl/pts_unloader_if.sv - block load and serial sample stream bundle for pts_unloader
interface pts_unloader_if #(
  parameter int NUM_SAMPLES = 48,
  parameter int SAMPLE_W    = 16
);
  logic                                    load_valid;
  logic                                    load_ready;
  logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0]    data_par;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [SAMPLE_W-1:0]                     serial_out;
  logic                                    out_last;
  logic                                    busy;

  // master: block producer / sample consumer side
  modport master (
    output load_valid, data_par, out_ready,
    input  load_ready, out_valid, serial_out, out_last, busy
  );

  // slave: the unloader itself
  modport slave (
    input  load_valid, data_par, out_ready,
    output load_ready, out_valid, serial_out, out_last, busy
  );
endinterface

// File: rtl/pts_unloader.sv
// rtl/pts_unloader.sv - parallel-to-serial block unloader, index 0 first; PTS_DBLBUF_EN adds a shadow block
module pts_unloader #(
  parameter int NUM_SAMPLES = 48,
  parameter int SAMPLE_W    = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  pts_unloader_if.slave bus
);
  localparam int              IDX_W = $clog2(NUM_SAMPLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SAMPLES - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                               state_q, state_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0] main_q, main_d;
`ifdef PTS_DBLBUF_EN
  logic [NUM_SAMPLES-1:0][SAMPLE_W-1:0] shadow_q, shadow_d;
  logic                                 shadow_full_q, shadow_full_d;
`endif

  logic                load_ready_c;
  logic                out_valid_c;
  logic                busy_c;
  logic                out_last_c;
  logic [SAMPLE_W-1:0] serial_out_c;
  logic                load_fire;
  logic                beat;
  logic                last_beat;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      main_q        <= '0;
`ifdef PTS_DBLBUF_EN
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      main_q        <= main_d;
`ifdef PTS_DBLBUF_EN
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    main_d    = main_q;
`ifdef PTS_DBLBUF_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif
    load_fire = bus.load_valid && load_ready_c;
    beat      = out_valid_c && bus.out_ready;
    last_beat = beat && (idx_q == LAST);
    unique case (state_q)
      IDLE: begin
        if (load_fire) begin
          main_d  = bus.data_par;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (beat && !last_beat) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (last_beat) begin
          idx_d = '0;
`ifdef PTS_DBLBUF_EN
          // Refill main without leaving STREAM so the next block follows with no bubble
          if (shadow_full_q) begin
            main_d        = shadow_q;
            shadow_full_d = 1'b0;
          end else if (load_fire) begin
            main_d = bus.data_par;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
`ifdef PTS_DBLBUF_EN
        if (load_fire && !last_beat) begin
          shadow_d      = bus.data_par;
          shadow_full_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready_c = 1'b0;
    out_valid_c  = 1'b0;
    busy_c       = 1'b0;
    unique case (state_q)
      IDLE: load_ready_c = 1'b1;
      STREAM: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
`ifdef PTS_DBLBUF_EN
        load_ready_c = !shadow_full_q;
`endif
      end
      default: load_ready_c = 1'b0;
    endcase
    serial_out_c = main_q[idx_q];
    out_last_c   = out_valid_c && (idx_q == LAST);
  end

  assign bus.load_ready = load_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.busy       = busy_c;
  assign bus.serial_out = serial_out_c;
  assign bus.out_last   = out_last_c;
endmodule

// File: tb/tb_pts_unloader.sv
// tb/tb_pts_unloader.sv - directed scoreboard bench for pts_unloader
module tb_pts_unloader;
  localparam int N = 48;
  localparam int W = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  pts_unloader_if #(.NUM_SAMPLES(N), .SAMPLE_W(W)) bus ();
  pts_unloader #(.NUM_SAMPLES(N), .SAMPLE_W(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [W:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [W-1:0] base, input bit push);
    for (int i = 0; i < N; i++) begin
      bus.data_par[i] = base + W'(i);
      if (push) sb.push_back({i == N - 1, W'(base + W'(i))});
    end
  endtask

  task automatic load_block(input logic [W-1:0] base);
    @(negedge clk);
    fill(base, 1'b1);
    bus.load_valid = 1'b1;
    check("load_ready_idle", 32'(bus.load_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  // Starts and ends on a negedge; pops the scoreboard on every transfer.
  task automatic run_stream(input int count, input bit bp, input int inj_at,
                            input logic [W-1:0] inj_base, input bit inj_ok,
                            input int rst_at, output int cycles);
    int n = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit injected = 1'b0;
    bit hold_off = 1'b0;
    logic [W:0] prev = '0;
    logic [W:0] exp;
    while (n < count && cyc < 4 * count + 16) begin
      bus.load_valid = 1'b0;
      if (rst_at >= 0 && n == rst_at) begin
        n_rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        sb.delete();
        cycles = cyc;
        return;
      end
      if (inj_at >= 0 && n == inj_at && !injected) begin
        injected = 1'b1;
        fill(inj_base, inj_ok);
        bus.load_valid = 1'b1;
        check("inject_load_ready", 32'(bus.load_ready), 32'(inj_ok));
        hold_off = inj_ok;
      end else if (hold_off && n < N) begin
        check("shadow_load_ready", 32'(bus.load_ready), 32'd0);
      end
      bus.out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      if (stalled)
        check("stall_stable", 32'({bus.out_last, bus.serial_out, bus.out_valid}), 32'({prev, 1'b1}));
      check("stream_valid", 32'({bus.out_valid, bus.busy}), 32'b11);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp = sb.pop_front();
          check("beat", 32'({bus.out_last, bus.serial_out}), 32'(exp));
        end
        n++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      prev = {bus.out_last, bus.serial_out};
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("beats_done", 32'(n), 32'(count));
    bus.load_valid = 1'b0;
    cycles = cyc;
  endtask

  int cyc;

  initial begin
    bus.load_valid = 1'b0;
    bus.out_ready  = 1'b0;
    bus.data_par   = '0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_serial_out", 32'(bus.serial_out), 32'd0);
    n_rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_load_ready", 32'(bus.load_ready), 32'd1);
      check("idle_outs", 32'({bus.out_valid, bus.out_last, bus.busy, bus.serial_out}), 32'd0);
    end

    // single block, no backpressure
    bus.out_ready = 1'b1;
    load_block(16'h1000);
    check("first_beat", 32'({bus.out_valid, bus.busy, bus.serial_out}), 32'h31000);
    run_stream(N, 1'b0, -1, '0, 1'b0, -1, cyc);
    check("single_cycles", 32'(cyc), 32'(N));
    check("post_idle", 32'({bus.load_ready, bus.out_valid, bus.busy}), 32'b100);
    check("sb_empty_single", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("idle_ignores_ready", 32'(bus.out_valid), 32'd0);

    // backpressure 1,0,0,1
    load_block(16'h2000);
    run_stream(N, 1'b1, -1, '0, 1'b0, -1, cyc);
    check("sb_empty_bp", 32'(sb.size()), 32'd0);
    bus.out_ready = 1'b1;

`ifndef PTS_DBLBUF_EN
    // load attempt mid-stream is refused
    load_block(16'h3000);
    run_stream(N, 1'b0, 10, 16'hB000, 1'b0, -1, cyc);
    check("refused_load_cycles", 32'(cyc), 32'(N));
    check("sb_empty_refused", 32'(sb.size()), 32'd0);
`endif

    // reset mid-stream
    load_block(16'h4000);
    run_stream(N, 1'b0, -1, '0, 1'b0, 20, cyc);
    repeat (2) begin
      @(negedge clk);
      check("in_reset_valid", 32'(bus.out_valid), 32'd0);
    end
    n_rst = 1'b1;
    @(negedge clk);
    check("after_rst_idle", 32'({bus.load_ready, bus.out_valid}), 32'b10);
    load_block(16'hA000);
    check("after_rst_first", 32'(bus.serial_out), 32'hA000);
    run_stream(N, 1'b0, -1, '0, 1'b0, -1, cyc);
    check("sb_empty_rst", 32'(sb.size()), 32'd0);

`ifdef PTS_DBLBUF_EN
    // double buffer: block B queued at beat 5 of A, 96 contiguous beats
    load_block(16'hC000);
    run_stream(2 * N, 1'b0, 5, 16'hD000, 1'b1, -1, cyc);
    check("dbl_cycles", 32'(cyc), 32'(2 * N));
    check("sb_empty_dbl", 32'(sb.size()), 32'd0);
    check("dbl_post_idle", 32'({bus.load_ready, bus.out_valid}), 32'b10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pts_unloader.md
Name: pts_unloader

Overview:
- Parallel-to-serial unloader for the FFT datapath.
- Accepts one full block of NUM_SAMPLES parallel samples from the FFT core, then streams them out one sample per beat on a valid/ready interface.
- Sample order: index 0 first, index NUM_SAMPLES-1 last. This is the inverse of the front-end serial-to-parallel capture, so a block round-trips in order.
- Sits between the FFT output stage and downstream serial consumers (output FIFO / interface logic).

Parameters:
- NUM_SAMPLES, 48: samples per block.
- SAMPLE_W, 16: bits per sample.

Ports:
- clk  input  1  system clock (400 MHz domain).
- n_rst  input  1  reset, asynchronous, active-low.
- load_valid  input  1  data_par holds a complete block to be loaded.
- load_ready  output  1  unloader can accept a block this cycle.
- data_par  input  [NUM_SAMPLES-1:0][SAMPLE_W-1:0]  parallel block.
- out_valid  output  1  serial_out carries a valid sample.
- out_ready  input  1  consumer accepts serial_out this cycle.
- serial_out  output  SAMPLE_W  current sample.
- out_last  output  1  current sample is index NUM_SAMPLES-1.
- busy  output  1  a block is being streamed (state STREAM).

Behaviour:
- Clock and reset: clk is the clock; n_rst is the reset, asynchronous, active-low.
- Reset clears all state:
  - state=IDLE, idx=0, main buffer=0.
  - out_valid=0, serial_out=0, out_last=0, busy=0.
  - load_ready=1 once the first clock edge follows reset release; load_ready is combinational from state.
- Reset mid-stream discards the partial block. No further beats of that block are emitted.
- Load handshake: a load is accepted on the rising edge where load_valid && load_ready. data_par is sampled only on that edge; data_par is don't-care at all other times.
- Output handshake: a beat transfers on the edge where out_valid && out_ready.
  - serial_out, out_last and out_valid must stay stable while out_valid=1 and out_ready=0.
  - out_ready is ignored while out_valid=0.
- idx counter: $clog2(NUM_SAMPLES) bits, range 0..NUM_SAMPLES-1, no wrap past NUM_SAMPLES-1.
- serial_out = main[idx]. out_last = (idx == NUM_SAMPLES-1) && out_valid.
- FSM state IDLE:
  - load_ready=1, out_valid=0, busy=0.
  - On load accept: main<=data_par, idx<=0, go to STREAM.
  - Latency: out_valid=1 with sample 0 in the cycle after the accept edge.
- FSM state STREAM:
  - out_valid=1, busy=1; load_ready=0 (double buffer disabled).
  - On a beat with idx<NUM_SAMPLES-1: idx<=idx+1.
  - On a beat with idx==NUM_SAMPLES-1: go to IDLE, idx<=0.
- Throughput without the option:
  - NUM_SAMPLES beats per block, plus one IDLE cycle between blocks.
  - Minimum period NUM_SAMPLES+1 cycles with out_ready held high.
- The upstream source must not assume a load was accepted unless load_ready was high on that edge.

Optional Feature:
- Macro: PTS_DBLBUF_EN.
- Defined: adds a shadow block register plus a shadow_full flag.
  - In STREAM, load_ready = !shadow_full; an accepted load writes the shadow and sets shadow_full.
  - On the last-beat edge with shadow_full=1: main<=shadow, shadow_full<=0, idx<=0, remain in STREAM. Zero bubble between blocks.
  - Last-beat edge coinciding with a load accept while shadow_full=0: data_par goes directly to main, idx<=0, remain in STREAM.
  - In IDLE, behaviour is unchanged and the shadow is unused.
  - Reset clears shadow_full and the shadow register.
- Undefined: no shadow storage; behaviour exactly as described in Behaviour.

Test Plan:
- Reset then idle: n_rst low for 3 cycles, then high -> load_ready=1; out_valid=0, serial_out=0, busy=0 held for 10 cycles.
- Single block, out_ready=1: load data_par[i]=16'h1000+i -> next cycle out_valid=1 and serial_out=16'h1000. 48 consecutive beats 16'h1000..16'h102F. out_last only on 16'h102F. Then IDLE with load_ready=1.
- Backpressure: out_ready toggles 1,0,0,1 repeating over a block -> serial_out/out_last stable during stalls. Exactly 48 transfers in order, none duplicated or lost.
- Load during STREAM (macro off): pulse load_valid=1 at beat 10 with a different block -> ignored (load_ready=0). Stream still emits the original block unchanged.
- Reset mid-stream: assert n_rst at beat 20 -> out_valid=0 immediately. After release, a new block 16'hA000+i streams from 16'hA000 with no stale samples.
- PTS_DBLBUF_EN: load block A, then load block B at beat 5 of A, with out_ready=1 -> 96 contiguous beats, A then B, no gap. out_last high on beats 47 and 95. load_ready=0 from the B accept until the A-to-B swap.
